// File: rtl/mem_arbiter.sv
// mem_arbiter: registered round-robin arbiter sharing one async memory port
// between an instruction cache (client 0) and a data cache (client 1).
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c0_read_req,
    input  logic [ADDR_WIDTH-1:0] c0_read_addr,
    output logic [WIDTH-1:0]      c0_read_data,
    output logic                  c0_read_ack,
    input  logic                  c0_write_req,
    input  logic [ADDR_WIDTH-1:0] c0_write_addr,
    input  logic [WIDTH-1:0]      c0_write_data,
    output logic                  c0_write_ack,
    input  logic                  c1_read_req,
    input  logic [ADDR_WIDTH-1:0] c1_read_addr,
    output logic [WIDTH-1:0]      c1_read_data,
    output logic                  c1_read_ack,
    input  logic                  c1_write_req,
    input  logic [ADDR_WIDTH-1:0] c1_write_addr,
    input  logic [WIDTH-1:0]      c1_write_data,
    output logic                  c1_write_ack,
    output logic                  mem_enable,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_data_in,
    output logic [3:0]            mem_byte_enable,
    input  logic [WIDTH-1:0]      mem_data_out,
    input  logic                  mem_ack
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    state_t state, state_n;
    logic gnt_client, gnt_client_n, gnt_write, gnt_write_n, last_client, last_client_n;
    logic mem_enable_n, mem_rw_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [WIDTH-1:0] mem_data_in_n;
    logic c0_req, c1_req, sel, sel_write, gnt_req, busy;
    assign c0_req = c0_read_req | c0_write_req;
    assign c1_req = c1_read_req | c1_write_req;
    assign sel = (c0_req & c1_req) ? ~last_client : c1_req;
    assign sel_write = sel ? c1_write_req : c0_write_req;
    assign gnt_req = gnt_client ? (gnt_write ? c1_write_req : c1_read_req)
                                : (gnt_write ? c0_write_req : c0_read_req);
    assign busy = state == BUSY;
    assign c0_read_ack  = busy & ~gnt_client & ~gnt_write & mem_ack;
    assign c0_write_ack = busy & ~gnt_client &  gnt_write & mem_ack;
    assign c1_read_ack  = busy &  gnt_client & ~gnt_write & mem_ack;
    assign c1_write_ack = busy &  gnt_client &  gnt_write & mem_ack;
    assign c0_read_data = mem_data_out;
    assign c1_read_data = mem_data_out;
    assign mem_byte_enable = 4'hf;
    // the !mem_ack guard keeps enable from rising onto a stale ack after a mid-transaction reset
    always_comb begin
        state_n       = state;
        gnt_client_n  = gnt_client;
        gnt_write_n   = gnt_write;
        last_client_n = last_client;
        mem_enable_n  = mem_enable;
        mem_rw_n      = mem_rw;
        mem_addr_n    = mem_addr;
        mem_data_in_n = mem_data_in;
        if (state == IDLE && (c0_req | c1_req) && !mem_ack) begin
            state_n       = BUSY;
            gnt_client_n  = sel;
            gnt_write_n   = sel_write;
            last_client_n = sel;
            mem_enable_n  = 1'b1;
            mem_rw_n      = ~sel_write;
            mem_addr_n    = sel ? (sel_write ? c1_write_addr : c1_read_addr)
                                : (sel_write ? c0_write_addr : c0_read_addr);
            mem_data_in_n = sel ? c1_write_data : c0_write_data;
        end else if (state == BUSY && !gnt_req) begin
            state_n      = DRAIN;
            mem_enable_n = 1'b0;
        end else if (state == DRAIN && !mem_ack) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt_client  <= 1'b0;
            gnt_write   <= 1'b0;
            last_client <= 1'b1;
            mem_enable  <= 1'b0;
            mem_rw      <= 1'b1;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            state       <= state_n;
            gnt_client  <= gnt_client_n;
            gnt_write   <= gnt_write_n;
            last_client <= last_client_n;
            mem_enable  <= mem_enable_n;
            mem_rw      <= mem_rw_n;
            mem_addr    <= mem_addr_n;
            mem_data_in <= mem_data_in_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;
    localparam int LATENCY = 30;
    logic clk = 0, reset = 1;
    logic c0_read_req = 0, c0_write_req = 0, c1_read_req = 0, c1_write_req = 0;
    logic [31:0] c0_read_addr = 0, c0_write_addr = 0, c0_write_data = 0;
    logic [31:0] c1_read_addr = 0, c1_write_addr = 0, c1_write_data = 0;
    logic [31:0] c0_read_data, c1_read_data, mem_addr, mem_data_in, mem_data_out;
    logic c0_read_ack, c0_write_ack, c1_read_ack, c1_write_ack;
    logic mem_enable, mem_rw, mem_ack;
    logic [3:0] mem_byte_enable;
    int checks = 0, errors = 0;

    typedef struct {
        logic [3:0]  ack;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .c0_read_req(c0_read_req), .c0_read_addr(c0_read_addr), .c0_read_data(c0_read_data),
        .c0_read_ack(c0_read_ack), .c0_write_req(c0_write_req), .c0_write_addr(c0_write_addr),
        .c0_write_data(c0_write_data), .c0_write_ack(c0_write_ack),
        .c1_read_req(c1_read_req), .c1_read_addr(c1_read_addr), .c1_read_data(c1_read_data),
        .c1_read_ack(c1_read_ack), .c1_write_req(c1_write_req), .c1_write_addr(c1_write_addr),
        .c1_write_data(c1_write_data), .c1_write_ack(c1_write_ack),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_byte_enable(mem_byte_enable), .mem_data_out(mem_data_out), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    int cnt;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
            mem_ack <= 0;
            cnt <= 0;
            mem_data_out <= 0;
        end else if (!mem_enable) begin
            mem_ack <= 0;
            cnt <= 0;
        end else if (!mem_ack) begin
            if (cnt == LATENCY - 1) begin
                mem_ack <= 1;
                mem_data_out <= mem[mem_addr[7:2]];
                if (!mem_rw) mem[mem_addr[7:2]] <= mem_data_in;
            end else cnt <= cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    wire [3:0] acks = {c1_write_ack, c1_read_ack, c0_write_ack, c0_read_ack};
    logic [3:0] prev_acks = 0;
    logic prev_en = 0, prev_rw = 0;
    logic [31:0] prev_addr = 0, prev_data = 0;

    always @(negedge clk) begin
        chk("byte_enable", {28'b0, mem_byte_enable}, 32'hf);
        chk("acks_onehot0", {31'b0, $onehot0(acks)}, 32'h1);
        if (acks != 0) chk("ack_without_enable", {31'b0, mem_enable}, 32'h1);
        if (prev_en && mem_enable) begin
            chk("stable_addr", mem_addr, prev_addr);
            chk("stable_rw", {31'b0, mem_rw}, {31'b0, prev_rw});
            chk("stable_data", mem_data_in, prev_data);
        end
        if (acks != 0 && prev_acks == 0) begin
            if (sb.size() == 0) chk("unexpected_ack", {28'b0, acks}, 32'h0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_channel", {28'b0, acks}, {28'b0, e.ack});
                chk("txn_addr", mem_addr, e.addr);
                chk("txn_rw", {31'b0, mem_rw}, {31'b0, ~(e.ack[1] | e.ack[3])});
                if (e.ack[1] | e.ack[3]) chk("write_data", mem_data_in, e.data);
                else chk("read_data", e.ack[2] ? c1_read_data : c0_read_data, e.data);
            end
        end
        prev_acks <= acks;
        prev_en <= mem_enable;
        prev_rw <= mem_rw;
        prev_addr <= mem_addr;
        prev_data <= mem_data_in;
    end

    function automatic logic ack_of(input int c, input bit w);
        return c != 0 ? (w ? c1_write_ack : c1_read_ack) : (w ? c0_write_ack : c0_read_ack);
    endfunction

    task automatic txn(input int c, input bit w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        case ({c[0], w})
            2'b00: begin c0_read_addr = a; c0_read_req = 1; end
            2'b01: begin c0_write_addr = a; c0_write_data = d; c0_write_req = 1; end
            2'b10: begin c1_read_addr = a; c1_read_req = 1; end
            default: begin c1_write_addr = a; c1_write_data = d; c1_write_req = 1; end
        endcase
        do begin @(negedge clk); n++; end while (!ack_of(c, w) && n < 400);
        chk("ack_arrived", {31'b0, ack_of(c, w)}, 32'h1);
        case ({c[0], w})
            2'b00: c0_read_req = 0;
            2'b01: c0_write_req = 0;
            2'b10: c1_read_req = 0;
            default: c1_write_req = 0;
        endcase
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_enable", {31'b0, mem_enable}, 32'h0);
        chk("rst_rw", {31'b0, mem_rw}, 32'h1);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_data", mem_data_in, 32'h0);
        chk("rst_acks", {28'b0, acks}, 32'h0);
        reset = 0;
        @(negedge clk);
        // single read
        sb.push_back('{4'b0001, 32'h004, 32'h1000_0001});
        c0_read_addr = 32'h004;
        c0_read_req = 1;
        @(negedge clk);
        chk("rd_enable", {31'b0, mem_enable}, 32'h1);
        chk("rd_rw", {31'b0, mem_rw}, 32'h1);
        chk("rd_addr", mem_addr, 32'h004);
        n = 0;
        while (!c0_read_ack && n < 400) begin @(negedge clk); n++; end
        chk("rd_ack", {31'b0, c0_read_ack}, 32'h1);
        c0_read_req = 0;
        @(negedge clk);
        chk("rd_enable_fall", {31'b0, mem_enable}, 32'h0);
        repeat (4) @(negedge clk);
        // abort before ack
        c0_read_addr = 32'h008;
        c0_read_req = 1;
        repeat (3) @(negedge clk);
        c0_read_req = 0;
        @(negedge clk);
        chk("abort_enable_fall", {31'b0, mem_enable}, 32'h0);
        repeat (4) @(negedge clk);
        // write before read on client 1
        sb.push_back('{4'b1000, 32'h00C, 32'hDEAD_BEEF});
        sb.push_back('{4'b0100, 32'h010, 32'h1000_0004});
        fork
            txn(1, 1, 32'h00C, 32'hDEAD_BEEF);
            txn(1, 0, 32'h010, 32'h0);
        join
        repeat (4) @(negedge clk);
        // round-robin with immediate re-requests
        sb.push_back('{4'b0001, 32'h020, 32'h1000_0008});
        sb.push_back('{4'b0100, 32'h00C, 32'hDEAD_BEEF});
        sb.push_back('{4'b0001, 32'h024, 32'h1000_0009});
        sb.push_back('{4'b0100, 32'h028, 32'h1000_000A});
        fork
            begin txn(0, 0, 32'h020, 0); @(negedge clk); txn(0, 0, 32'h024, 0); end
            begin txn(1, 0, 32'h00C, 0); @(negedge clk); txn(1, 0, 32'h028, 0); end
        join
        repeat (4) @(negedge clk);
        // reset during a client 1 write
        c1_write_addr = 32'h030;
        c1_write_data = 32'h1234_5678;
        c1_write_req = 1;
        n = 0;
        while (!mem_enable && n < 20) begin @(negedge clk); n++; end
        chk("rst_mid_granted", {31'b0, mem_enable}, 32'h1);
        repeat (5) @(negedge clk);
        reset = 1;
        c1_write_req = 0;
        @(negedge clk);
        reset = 0;
        chk("rst_mid_enable", {31'b0, mem_enable}, 32'h0);
        chk("rst_mid_acks", {28'b0, acks}, 32'h0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        repeat (3) @(negedge clk);
        sb.push_back('{4'b0001, 32'h034, 32'h1000_000D});
        sb.push_back('{4'b0100, 32'h038, 32'h1000_000E});
        fork
            txn(0, 0, 32'h034, 0);
            txn(1, 0, 32'h038, 0);
        join
        repeat (6) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory_async port between two cache clients: client 0 is the instruction cache and client 1 is the data cache.
- Each client has a read-refill channel and a write-back channel, using the same req/ack signals as the cache mem_* ports.
- Replaces ad-hoc combinational glue with a registered FSM.
- Arbitration:
  - between clients: round-robin;
  - within a client: the write channel wins over the read channel, so write-back happens before refill.

Parameters:
- WIDTH, 32, data width of all data buses.
- ADDR_WIDTH, 32, width of all address buses.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- c0_read_req  in  1  client 0 read request; held until ack.
- c0_read_addr  in  ADDR_WIDTH  client 0 read address.
- c0_read_data  out  WIDTH  client 0 read data; valid while c0_read_ack=1.
- c0_read_ack  out  1  client 0 read done.
- c0_write_req  in  1  client 0 write request; held until ack.
- c0_write_addr  in  ADDR_WIDTH  client 0 write address.
- c0_write_data  in  WIDTH  client 0 write data.
- c0_write_ack  out  1  client 0 write done.
- c1_read_req, c1_read_addr, c1_read_data, c1_read_ack, c1_write_req, c1_write_addr, c1_write_data, c1_write_ack: same as client 0.
- mem_enable  out  1  memory master_enable.
- mem_rw  out  1  memory read_write; 1=read, 0=write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data_in  out  WIDTH  memory write data.
- mem_byte_enable  out  4  constant 4'hf.
- mem_data_out  in  WIDTH  memory read data.
- mem_ack  in  1  memory ack; held high until mem_enable drops.

Behaviour:
- FSM states: IDLE, BUSY, DRAIN. Registers:
  - gnt_client (1 bit);
  - gnt_write (1 bit);
  - last_client (1 bit);
  - latched addr and data.
- Reset, synchronous:
  - state=IDLE, last_client=1 (client 0 wins first);
  - mem_enable=0, mem_rw=1, mem_addr=0, mem_data_in=0;
  - all acks=0.
  - Reset has priority over everything, including mid-transaction. The memory then sees mem_enable fall; no ack is delivered to any client.
- IDLE:
  - At a posedge with any req high, select the client:
    - if only one client requests, take it;
    - if both request, take the one that is not last_client.
  - Within the selected client, write_req wins over read_req.
  - Latch addr, data and the rw flag (write→0, read→1).
  - Set mem_enable=1, go to BUSY, and set last_client to the granted client.
  - Latency: req sampled at edge N gives mem_enable=1 after edge N. Minimum 1 cycle.
- BUSY:
  - The granted channel's ack = mem_ack, combinationally gated by state==BUSY and the grant. All other acks stay 0.
  - read_data for both clients = mem_data_out, broadcast; only the ack qualifies it.
  - mem_addr, mem_rw and mem_data_in hold stable for the whole transaction.
  - When the granted req is sampled low (normal completion, or abort before ack): mem_enable=0 at that edge, go to DRAIN.
  - Changes on non-granted reqs are ignored.
- DRAIN:
  - mem_enable=0. All acks forced 0, even if mem_ack is still high.
  - Go to IDLE at the first edge with mem_ack=0.
  - No new grant is issued in DRAIN, so at least one idle cycle separates transactions to the memory.
- Fairness:
  - A client re-requesting immediately after its own transaction loses to a pending request from the other client.
  - Both channels of one client pending: write served first, then read on the client's next grant.
- Invariants:
  - At most one ack high in any cycle.
  - No ack is ever high while mem_enable=0.
  - mem_enable never rises while mem_ack=1.

Test Plan:
- Single read:
  - Stimulus: reset, then c0_read_req=1, c0_read_addr=0x004, memory LATENCY=30.
  - Required: mem_enable rises 1 cycle later with mem_rw=1 and mem_addr=0x004. c0_read_ack rises with mem_ack, and c0_read_data equals memory word 1.
  - Then drop req: mem_enable falls at the next edge, DRAIN→IDLE once mem_ack=0.
- Write before read:
  - Stimulus: c1_write_req (addr 0x00C, data 0xDEADBEEF) and c1_read_req (addr 0x010) raised together.
  - Required: first transaction has mem_rw=0, addr 0x00C, data 0xDEADBEEF, and c1_write_ack. After DRAIN, c1 is granted again for the read to 0x010 only because c0 is idle.
- Round-robin:
  - Stimulus: c0_read_req and c1_read_req held continuously, each dropped after its ack and re-raised 1 cycle later.
  - Required: grant order c0, c1, c0, c1; c1_read_ack never high during a c0 grant.
- Abort:
  - Stimulus: c0 raises read_req and drops it 3 cycles later, before mem_ack.
  - Required: mem_enable falls at the next edge; c0_read_ack never asserts; FSM returns to IDLE after mem_ack stays 0.
- Reset mid-operation:
  - Stimulus: reset=1 for 1 cycle during BUSY on a c1 write.
  - Required: after that edge mem_enable=0, all acks 0, state IDLE. On the next simultaneous requests, client 0 is granted first.
- Invariant monitor across all runs:
  - one-hot-or-zero acks;
  - ack implies mem_enable;
  - mem_addr/mem_rw/mem_data_in constant while mem_enable=1;
  - mem_byte_enable always 4'hf.
